// File: rtl/screen_pixel_pipe_if.sv
// Pixel pipe bus: fetcher bytes, timing strobes, palette handshake and colour out.
interface screen_pixel_pipe_if;
  logic       ce_pix;
  logic       load;
  logic [7:0] bitmap;
  logic [7:0] attr;
  logic       border_en;
  logic [2:0] border;
  logic       blank;
  logic       frame;
  logic       ulaplus_active;
  logic [5:0] ink_addr;
  logic [5:0] paper_addr;
  logic [7:0] ink;
  logic [7:0] paper;
  logic [2:0] r;
  logic [2:0] g;
  logic [2:0] b;

  // Fetcher/palette/DAC side
  modport master (
    output ce_pix, load, bitmap, attr, border_en, border, blank, frame,
           ulaplus_active, ink, paper,
    input  ink_addr, paper_addr, r, g, b
  );

  // Pixel pipe side
  modport slave (
    input  ce_pix, load, bitmap, attr, border_en, border, blank, frame,
           ulaplus_active, ink, paper,
    output ink_addr, paper_addr, r, g, b
  );
endinterface

// File: rtl/screen_pixel_pipe.sv
// Two-stage pixel serialiser: stage A shifts bitmap and issues palette
// addresses, stage B resolves the colour (ULAplus palette or classic + FLASH).
module screen_pixel_pipe (
  input  logic                clk28,
  input  logic                rst_n,
  screen_pixel_pipe_if.slave  bus
);

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned CH_W    = 3;
  localparam int unsigned FLASH_W = 5;

  // Stage A state
  logic [BYTE_W-1:0]  shreg;
  logic [BYTE_W-1:0]  attr_q;
  logic               border_a;
  logic               blank_a;
  logic [CH_W-1:0]    border_a_col;
  logic [ADDR_W-1:0]  ink_addr_q;
  logic [ADDR_W-1:0]  paper_addr_q;

  // Stage B / misc state
  logic [FLASH_W-1:0] flash_cnt;
  logic [CH_W-1:0]    r_q, g_q, b_q;

  // Combinational helpers
  logic [BYTE_W-1:0]  shreg_nxt_c;
  logic [BYTE_W-1:0]  attr_nxt_c;
  logic               pix_a_c;
  logic [BYTE_W-1:0]  entry_c;
  logic               ink_sel_c;
  logic [CH_W-1:0]    col_c;
  logic [CH_W-1:0]    lvl_c;
  logic [CH_W-1:0]    r_nxt_c, g_nxt_c, b_nxt_c;

  // Stage A next values: load a new byte pair or shift in zeros
  always_comb begin
    shreg_nxt_c = {shreg[BYTE_W-2:0], 1'b0};
    attr_nxt_c  = attr_q;
    if (bus.load) begin
      shreg_nxt_c = bus.bitmap;
      attr_nxt_c  = bus.attr;
    end
  end

  // Stage A registers and palette addresses, advanced on each pixel strobe
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      shreg        <= '0;
      attr_q       <= '0;
      border_a     <= 1'b0;
      blank_a      <= 1'b0;
      border_a_col <= '0;
      ink_addr_q   <= '0;
      paper_addr_q <= '0;
    end else if (bus.ce_pix) begin
      shreg        <= shreg_nxt_c;
      attr_q       <= attr_nxt_c;
      border_a     <= bus.border_en;
      blank_a      <= bus.blank;
      border_a_col <= bus.border;
      if (bus.border_en) begin
        paper_addr_q <= {3'b001, bus.border};
      end else begin
        ink_addr_q   <= {attr_nxt_c[7:6], 1'b0, attr_nxt_c[2:0]};
        paper_addr_q <= {attr_nxt_c[7:6], 1'b1, attr_nxt_c[5:3]};
      end
    end
  end

  // Stage A pixel is the MSB of the updated shifter; attr_q still holds
  // the attribute that went with it until the next strobe edge.
  assign pix_a_c = shreg[BYTE_W-1];

  // Stage B colour resolution
  always_comb begin
    r_nxt_c   = '0;
    g_nxt_c   = '0;
    b_nxt_c   = '0;
    entry_c   = (border_a || !pix_a_c) ? bus.paper : bus.ink;
    ink_sel_c = pix_a_c ^ (attr_q[7] & flash_cnt[FLASH_W-1]);
    col_c     = border_a ? border_a_col
                         : (ink_sel_c ? attr_q[2:0] : attr_q[5:3]);
    lvl_c     = (!border_a && attr_q[6]) ? 3'd7 : 3'd5;
    if (blank_a) begin
      r_nxt_c = '0;
      g_nxt_c = '0;
      b_nxt_c = '0;
    end else if (bus.ulaplus_active) begin
      r_nxt_c = entry_c[4:2];
      g_nxt_c = entry_c[7:5];
      b_nxt_c = {entry_c[1:0], entry_c[1] | entry_c[0]};
    end else begin
      g_nxt_c = col_c[2] ? lvl_c : 3'd0;
      r_nxt_c = col_c[1] ? lvl_c : 3'd0;
      b_nxt_c = col_c[0] ? lvl_c : 3'd0;
    end
  end

  // Stage B output registers
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else if (bus.ce_pix) begin
      r_q <= r_nxt_c;
      g_q <= g_nxt_c;
      b_q <= b_nxt_c;
    end
  end

  // FLASH phase counter, one step per frame
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      flash_cnt <= '0;
    end else if (bus.frame) begin
      flash_cnt <= flash_cnt + FLASH_W'(1);
    end
  end

  assign bus.ink_addr   = ink_addr_q;
  assign bus.paper_addr = paper_addr_q;
  assign bus.r          = r_q;
  assign bus.g          = g_q;
  assign bus.b          = b_q;

endmodule

// File: doc/screen_pixel_pipe.md
# screen_pixel_pipe

Pixel-serialising stage between the screen memory fetcher and the video DAC. It takes each fetched bitmap/attribute byte pair and shifts out one pixel per pixel strobe. It drives the ULAplus palette lookup addresses (`ink_addr`/`paper_addr`) and turns the returned 8-bit G3R3B2 palette entries into 3:3:3 RGB. When ULAplus is inactive it produces classic Spectrum colours and FLASH itself.

## Interface
Parameters:
- none

Ports:
- `clk28` in 1: system clock, 28 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `ce_pix` in 1: pixel strobe, one `clk28` cycle wide, exactly every 4th `clk28` cycle.
- `load` in 1: qualified by `ce_pix`; load `bitmap`/`attr` for the next 8 pixels.
- `bitmap` in 8: pixel byte, MSB is the leftmost pixel.
- `attr` in 8: attribute byte. Bit 7 FLASH, bit 6 BRIGHT, bits 5:3 PAPER, bits 2:0 INK.
- `border_en` in 1: sampled on `ce_pix`; current pixel is border.
- `border` in 3: border colour index (GRB).
- `blank` in 1: sampled on `ce_pix`; current pixel is blanked.
- `frame` in 1: one-cycle strobe per frame; advances the FLASH counter.
- `ulaplus_active` in 1: ULAplus palette mode.
- `ink_addr` out 6: palette address for ink.
- `paper_addr` out 6: palette address for paper.
- `ink` in 8: palette entry for `ink_addr`, G[7:5] R[4:2] B[1:0].
- `paper` in 8: palette entry for `paper_addr`, same format.
- `r`, `g`, `b` out 3 each: registered pixel colour.

## Operation
Reset values: all outputs 0. Internal registers are also 0: `shreg`, `attr_q`, the stage A/B bits and `flash_cnt`.

Stage A, on `ce_pix`:
- If `load`: `shreg <= bitmap`, `attr_q <= attr`.
- Otherwise: `shreg <= shreg << 1`, zero fill. With no further `load`, the pixel after 8 shifts is 0, which gives paper colour.
- `load` without `ce_pix` is ignored.
- `pix_a` is the MSB of the shift register after the update. That is `bitmap[7]` on a load cycle.
- `border_en` and `blank` are captured into `border_a` and `blank_a`.
- `ink_addr` and `paper_addr` are registered on the same `ce_pix`:
  - Pixel cycle, group g = {`attr_q`.FLASH, `attr_q`.BRIGHT} of the new value: `ink_addr` = {g, 1'b0, INK}, `paper_addr` = {g, 1'b1, PAPER}.
  - Border cycle: `paper_addr` = {3'b001, `border`}, i.e. 8+border. `ink_addr` is unchanged.
- The addresses are driven regardless of `ulaplus_active`.

Stage B, on the next `ce_pix`, registers `r`, `g`, `b`:
- `blank_a` = 1 → 0,0,0.
- ULAplus mode:
  - Selected entry: `paper` if `border_a` or not `pix_a`; otherwise `ink`.
  - `r` = E[4:2], `g` = E[7:5], `b` = {E[1:0], E[1]|E[0]}.
- Classic mode:
  - Ink select: `pix_a` XOR (`attr_a`.FLASH AND `flash_cnt[4]`).
  - Colour index c = INK or PAPER, or `border` on a border pixel.
  - Level L = 7 if BRIGHT, otherwise 5. Border always uses L = 5.
  - `g` = c[2] ? L : 0, `r` = c[1] ? L : 0, `b` = c[0] ? L : 0.
  - BRIGHT black stays 0.
- `attr_a` is `attr_q` as it was at the stage-A update that produced `pix_a`.

FLASH counter:
- `flash_cnt` is 5 bits and increments on `frame`, wrapping 31 → 0.
- Phase `flash_cnt[4]` toggles every 16 frames.
- FLASH has no effect in ULAplus mode.

`ulaplus_active` is sampled at stage B. A mid-line change takes effect on the next output pixel.

## Timing
- Latency: `load`+`ce_pix` at strobe N → that byte's leftmost pixel appears on `r`/`g`/`b` after strobe N+1. Subsequent pixels follow one per strobe.
- Palette handshake: addresses are stable for 4 `clk28` cycles, from strobe N to N+1. The palette must return `ink` and `paper` within 3 cycles; stage B samples them at strobe N+1.
- Back-to-back loads every 8 strobes give continuous pixels with no gap or duplicate.
- A `frame` strobe coinciding with `ce_pix` is honoured; the new FLASH phase applies from stage B of the next strobe.
- Reset asserted mid-line: all state clears immediately and outputs read 0 on the next cycle. Output resumes 2 strobes after the first `load` following reset release.

## Test plan
- Classic mode: attr=0x47, bitmap=0xA5 → sequence white (7,7,7) / black, alternating per the bits 1,0,1,0,0,1,0,1, starting one strobe after load.
- ULAplus mode: attr=0xC2, bitmap=0x80. Palette returns `ink`=0xE3 and `paper`=0x1C. Check `ink_addr`=0x32 and `paper_addr`=0x38. Outputs: pixel 0 → r=0, g=7, b=7; pixels 1–7 → r=7, g=0, b=0.
- FLASH: classic mode, attr=0x81, bitmap=0xFF. Before 16 `frame` strobes → blue (b=5). After 16 → black. After 32 → blue again.
- Border: `border_en`=1, `border`=5 (G=1, B=1), classic mode → g=5, r=0, b=5. ULAplus mode → `paper_addr`=13 and the output is the `paper` entry.
- Blank and reset: `blank`=1 → 0,0,0 one strobe later. Assert `rst_n`=0 mid-byte → outputs 0 and `flash_cnt` cleared; a reload after release gives correct pixels 2 strobes later.
